// File: rtl/sfr_initiator.sv
// rtl/sfr_initiator.sv - single-outstanding command-to-SFR bus initiator with timeout
//
// Purpose: accepts one host command at a time. It turns the command into a
// write or read access on a simple SFR bus, waits for the bus acknowledge or
// a timeout, and returns one response to the host. Misaligned addresses
// complete at once with an error and make no bus access.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready      host command handshake
//   cmd_write, cmd_addr,     command fields: direction, byte address,
//   cmd_wdata, cmd_wstrb       write data and byte strobes
//   rsp_valid/rsp_ready      host response handshake
//   rsp_rdata, rsp_error     read data (0 for writes and errors), error flag
//   o_wr_en, o_waddr,        bus write request, address, data and strobes
//   o_wdata, o_wstrobe
//   o_rd_en, o_raddr         bus read request and address
//   i_rdata, i_rvalid        bus read data and read acknowledge
//   i_wready                 bus write acknowledge
//   err_count                saturating count of error responses
module sfr_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        o_wr_en,
  output logic        o_rd_en,
  output logic [31:0] o_waddr,
  output logic [31:0] o_raddr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrobe,
  input  logic [31:0] i_rdata,
  input  logic        i_wready,
  input  logic        i_rvalid,
  output logic [7:0]  err_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // The counter holds (cycles already spent waiting - 1) in the current bus
  // cycle, so the last allowed wait cycle is the one where it equals N-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic       ready_q;     // keeps cmd_ready low until the first edge after reset
  logic [7:0] wait_cnt;
  logic       accept;
  logic       timeout;

  assign cmd_ready = ready_q && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign timeout   = (wait_cnt == WAIT_LAST);

  // Enables decode straight from state so a reset drops them asynchronously
  // and they can never be high together.
  assign o_wr_en   = (state == WRITE);
  assign o_rd_en   = (state == READ);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      wait_cnt  <= 8'd0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      o_waddr   <= 32'd0;
      o_raddr   <= 32'd0;
      o_wdata   <= 32'd0;
      o_wstrobe <= 4'd0;
      err_count <= 8'd0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= 8'd0;
            if (cmd_addr[1:0] != 2'b00) begin
              state     <= RESP;
              rsp_error <= 1'b1;
              rsp_rdata <= 32'd0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (cmd_write) begin
              state     <= WRITE;
              o_waddr   <= cmd_addr;
              o_wdata   <= cmd_wdata;
              o_wstrobe <= cmd_wstrb;
            end else begin
              state   <= READ;
              o_raddr <= cmd_addr;
            end
          end
        end
        WRITE: begin
          wait_cnt <= wait_cnt + 8'd1;
          // Acknowledge is tested first so it wins over a same-cycle timeout.
          if (i_wready) begin
            state     <= RESP;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'd0;
          end else if (timeout) begin
            state     <= RESP;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        READ: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (i_rvalid) begin
            state     <= RESP;
            rsp_error <= 1'b0;
            rsp_rdata <= i_rdata;
          end else if (timeout) begin
            state     <= RESP;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: begin
          // RESP: hold the response until the host takes it.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfr_initiator.sv
// tb/tb_sfr_initiator.sv - table-driven bench for sfr_initiator
`timescale 1ns/1ps
module tb_sfr_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        o_wr_en, o_rd_en;
  logic [31:0] o_waddr, o_raddr, o_wdata;
  logic [3:0]  o_wstrobe;
  logic [31:0] i_rdata;
  logic        i_wready, i_rvalid;
  logic [7:0]  err_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  sfr_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .o_wr_en(o_wr_en), .o_rd_en(o_rd_en),
    .o_waddr(o_waddr), .o_raddr(o_raddr), .o_wdata(o_wdata),
    .o_wstrobe(o_wstrobe), .i_rdata(i_rdata), .i_wready(i_wready),
    .i_rvalid(i_rvalid), .err_count(err_count)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_dly;   // cycles after enable rise; -1 = never
    logic [31:0] rdata;
    int          exp_en;    // cycles the enable is high
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   en_cycles;
    int   t;
    bit   hold_ok, excl_ok, got;
    logic ack;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb; rsp_ready = 1'b1;
    // Opposite-direction acknowledge held high: must be ignored.
    if (v.wr) i_rvalid = 1'b1; else i_wready = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = ~v.wdata; cmd_wstrb = 4'h0;
    en_cycles = 0; hold_ok = 1; excl_ok = 1; got = 0;
    for (t = 0; t < 300 && !got; t++) begin
      if (o_wr_en && o_rd_en) excl_ok = 0;
      if (o_wr_en) begin
        en_cycles++;
        if (o_waddr !== v.addr || o_wdata !== v.wdata || o_wstrobe !== v.wstrb) hold_ok = 0;
      end
      if (o_rd_en) begin
        en_cycles++;
        if (o_raddr !== v.addr) hold_ok = 0;
      end
      if (rsp_valid) begin
        got = 1;
      end else begin
        ack = (v.ack_dly >= 0) && (en_cycles == v.ack_dly + 1);
        if (v.wr) i_wready = ack;
        else begin
          i_rvalid = ack;
          i_rdata  = ack ? v.rdata : 32'hDEAD_BEEF;
        end
        @(negedge clk);
      end
    end
    if (v.exp_err) exp_errs++;
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    check({tag, " en_cycles"}, en_cycles, v.exp_en);
    check({tag, " bus_hold"}, 32'(hold_ok), 32'd1);
    check({tag, " en_excl"}, 32'(excl_ok), 32'd1);
    check({tag, " rsp_error"}, 32'(rsp_error), 32'(v.exp_err));
    check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " err_count"}, 32'(err_count), exp_errs);
    i_wready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit ok;
    reset_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0; i_rdata = 32'hDEAD_BEEF; i_wready = 0; i_rvalid = 0;

    //                wr    addr          wdata          strb  dly rdata          en err rdata
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'hF,  1, 32'h0,          2, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,  2, 32'h5,          3, 1'b0, 32'h5};
    vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, -1, 32'h0,         16, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0006, 32'h1111_2222, 4'hF,  0, 32'h0,          0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0,  0, 32'h1234_5678,  1, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 4'h3, 15, 32'h0,         16, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0001, 32'h0,         4'h0,  0, 32'h0,          0, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 15, 32'hCAFE_F00D, 16, 1'b0, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h0000_0024, 32'h5555_AAAA, 4'h9, -1, 32'h0,         16, 1'b1, 32'h0};

    // Reset state and first ready edge.
    repeat (3) @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst enables", {30'd0, o_wr_en, o_rd_en}, 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rel cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Response back-pressure: rsp held for 5 cycles, no acceptance until after handshake.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30; rsp_ready = 0;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h2;           // pending misaligned write
    i_rvalid = 1; i_rdata = 32'h77;
    @(negedge clk);
    i_rvalid = 0; i_rdata = 32'hDEAD_BEEF;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || rsp_rdata !== 32'h77 || rsp_error || cmd_ready) ok = 0;
      if (i < 4) @(negedge clk);
    end
    check("bp held_5_cycles", 32'(ok), 32'd1);
    check("bp rsp_rdata", rsp_rdata, 32'h77);
    rsp_ready = 1;
    @(negedge clk);
    check("bp rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check("bp cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 0;
    exp_errs++;
    check("bp next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp next_rsp_error", 32'(rsp_error), 32'd1);
    check("bp err_count", 32'(err_count), exp_errs);

    // Saturation: stream misaligned commands well past 255 errors.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3; rsp_ready = 1;
    repeat (600) @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    check("sat err_count", 32'(err_count), 32'd255);

    // Reset in the middle of a write.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 0;
    check("mid wr_en_before_rst", 32'(o_wr_en), 32'd1);
    #2 reset_n = 0;
    #1;
    check("mid wr_en_async_drop", 32'(o_wr_en), 32'd0);
    check("mid err_count_cleared", 32'(err_count), 32'd0);
    @(negedge clk);
    reset_n = 1;
    ok = 1;
    @(negedge clk);
    check("mid cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) ok = 0;
      @(negedge clk);
    end
    check("mid no_response", 32'(ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sfr_initiator.md
SFR_INITIATOR -- requirements
Module: sfr_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a bus access waits for acknowledge (legal range 2..255).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  block accepts a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  byte address.
- cmd_wdata  input  32  write data.
- cmd_wstrb  input  4  write byte strobes.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_rdata  output  32  read data; 0 for writes and for errors.
- rsp_error  output  1  1 = timeout or misaligned address.
- o_wr_en  output  1  bus write enable.
- o_rd_en  output  1  bus read enable.
- o_waddr  output  32  bus write address.
- o_raddr  output  32  bus read address.
- o_wdata  output  32  bus write data.
- o_wstrobe  output  4  bus write strobes.
- i_rdata  input  32  bus read data.
- i_wready  input  1  bus write acknowledge.
- i_rvalid  input  1  bus read-data valid.
- err_count  output  8  saturating count of error responses.

Function
REQ-003 The FSM SHALL have four states: IDLE, WRITE, READ, RESP.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-005 On acceptance with cmd_addr[1:0] != 0, the FSM SHALL go to RESP with rsp_error=1 and rsp_rdata=0, and SHALL make no bus access.
REQ-006 On acceptance of an aligned write, the FSM SHALL go to WRITE; from the next cycle, o_wr_en=1, o_waddr=cmd_addr, o_wdata=cmd_wdata and o_wstrobe=cmd_wstrb.
REQ-007 On acceptance of an aligned read, the FSM SHALL go to READ; from the next cycle, o_rd_en=1 and o_raddr=cmd_addr.
REQ-008 Bus address, data and strobe outputs SHALL be registered at acceptance and held stable until the access ends.
REQ-009 o_wr_en and o_rd_en SHALL never be 1 in the same cycle.
REQ-010 In WRITE, a sampled i_wready=1 SHALL end the access; o_wr_en drops to 0 the next cycle, and the FSM goes to RESP with rsp_error=0 and rsp_rdata=0.
REQ-011 In READ, a sampled i_rvalid=1 SHALL capture i_rdata into rsp_rdata; o_rd_en drops to 0 the next cycle, and the FSM goes to RESP with rsp_error=0.
REQ-012 An 8-bit wait counter SHALL clear at acceptance and increment each cycle spent in WRITE or READ.
REQ-013 If the counter reaches TIMEOUT_CYCLES with no acknowledge, the enable SHALL drop and the FSM SHALL go to RESP with rsp_error=1 and rsp_rdata=0.
REQ-014 If the acknowledge arrives in the same cycle the timeout is reached, the acknowledge SHALL win.
REQ-015 i_rvalid in WRITE, i_wready in READ, and either acknowledge in IDLE or RESP SHALL be ignored.
REQ-016 In RESP, rsp_valid=1 and rsp_rdata/rsp_error SHALL be held stable until rsp_ready=1; the FSM then returns to IDLE.
REQ-017 Best-case latency SHALL be: acceptance at cycle N, enable at N+1, acknowledge at N+1, rsp_valid at N+2.
REQ-018 A new command SHALL NOT be accepted in the cycle rsp_valid && rsp_ready; the earliest next acceptance is the following cycle.
REQ-019 err_count SHALL increment by 1 on each entry to RESP with rsp_error=1 and SHALL saturate at 255.

Reset
REQ-020 While reset_n=0, all state SHALL asynchronously clear: FSM=IDLE, all outputs 0 (cmd_ready=0 during reset), counters 0.
REQ-021 cmd_ready SHALL become 1 on the first clk edge after reset_n deasserts.
REQ-022 Reset during WRITE, READ or RESP SHALL abandon the transaction without emitting a response.

Verification
REQ-023 Write 0xA5A5_0001 to address 0x8 with strobe 0xF, i_wready returned 1 cycle after o_wr_en -> o_waddr=0x8, o_wdata=0xA5A5_0001 held while o_wr_en=1; rsp_valid=1, rsp_error=0.
REQ-024 Read address 0x0, i_rvalid with i_rdata=0x5 two cycles after o_rd_en -> rsp_rdata=0x5, rsp_error=0, o_rd_en high exactly 3 cycles.
REQ-025 Read address 0xC with no acknowledge and TIMEOUT_CYCLES=16 -> o_rd_en high 16 cycles, then rsp_error=1, rsp_rdata=0, err_count=1.
REQ-026 Write to address 0x6 -> no o_wr_en pulse; rsp_error=1 on the cycle after acceptance.
REQ-027 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles; cmd_ready=0 throughout; acceptance possible one cycle after the handshake.
REQ-028 reset_n pulsed low mid-WRITE -> o_wr_en=0 immediately (asynchronously); no rsp_valid; cmd_ready=1 one cycle after release.
